// File: rtl/light_level_ctrl_pkg.sv
// Shared types and word-slicing constants for the light level controller.
package light_ctrl_pkg;

   typedef enum logic {
      PRIME = 1'b0,
      RUN   = 1'b1
   } state_t;

   localparam int SAMPLE_W   = 8;
   localparam int SAMPLE_MSB = 11;
   localparam int SAMPLE_LSB = 4;
   localparam int HDR_MSB    = 15;
   localparam int HDR_LSB    = 12;

   function automatic logic [SAMPLE_W-1:0] extract_sample(input logic [15:0] word);
      return word[SAMPLE_MSB:SAMPLE_LSB];
   endfunction

   function automatic logic header_ok(input logic [15:0] word);
      return (word[HDR_MSB:HDR_LSB] == '0);
   endfunction

endpackage

// File: rtl/light_level_ctrl_pwm_gen.sv
// Free-running PWM: duty is taken only at counter wrap so a period is never torn;
// i_zero kills the duty immediately (lamp off at once).
module pwm_gen #(
   parameter int PWM_BITS = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_zero,
   input  logic [PWM_BITS-1:0] i_duty,
   output logic                o_pwm
);

   logic [PWM_BITS-1:0] r_cnt;
   logic [PWM_BITS-1:0] r_duty;
   logic                r_pwm;
   logic                w_wrap;

   assign w_wrap = &r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_duty <= '0;
         r_pwm  <= 1'b0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
         if (i_zero)
            r_duty <= '0;
         else if (w_wrap)
            r_duty <= i_duty;
         r_pwm <= (r_cnt < r_duty);
      end
   end

   assign o_pwm = r_pwm;

endmodule

// File: rtl/light_level_ctrl.sv
// Moving-average light level with hysteresis dark flag and inverse-brightness lamp PWM.
// Optional no-frame watchdog enabled by defining LIGHT_STALE_EN.
module light_level_ctrl
   import light_ctrl_pkg::*;
#(
   parameter int          AVG_LOG2     = 3,
   parameter logic [7:0]  TH_LOW       = 8'd96,
   parameter logic [7:0]  TH_HIGH      = 8'd160,
   parameter int          PWM_BITS     = 8,
   parameter int          STALE_CYCLES = 5000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] word_in,
   input  logic        word_valid,
   input  logic        clear,
   output logic [7:0]  avg_val,
   output logic        avg_valid,
   output logic        dark,
   output logic        pwm_out,
   output logic        frame_err,
   output logic        stale
);

   localparam int DEPTH = 1 << AVG_LOG2;
   localparam int SUM_W = SAMPLE_W + AVG_LOG2;

   if (AVG_LOG2 < 1 || PWM_BITS < SAMPLE_W || STALE_CYCLES < 1) begin : g_param_chk
      $error("light_level_ctrl: unsupported parameter combination");
   end

   state_t                r_state;
   state_t                w_state_nxt;
   logic [SAMPLE_W-1:0]   r_buf [DEPTH];
   logic [SUM_W-1:0]      r_sum;
   logic [AVG_LOG2-1:0]   r_ptr;
   logic                  r_upd;
   logic [7:0]            r_avg;
   logic                  r_avg_vld;
   logic                  r_dark;
   logic                  r_ferr;

   logic                  w_hdr_ok;
   logic [SAMPLE_W-1:0]   w_sample;
   logic                  w_accept;
   logic                  w_reject;
   logic [7:0]            w_avg_new;
   logic                  w_stale;
   logic                  w_dark_out;
   logic [PWM_BITS-1:0]   w_duty;
   logic                  w_unused_lsbs;

   assign w_hdr_ok      = header_ok(word_in);
   assign w_sample      = extract_sample(word_in);
   assign w_accept      = word_valid & w_hdr_ok & ~clear;
   assign w_reject      = word_valid & ~w_hdr_ok & ~clear;
   assign w_avg_new     = r_sum[SUM_W-1:AVG_LOG2];
   assign w_unused_lsbs = ^word_in[SAMPLE_LSB-1:0];

   always_comb begin
      w_state_nxt = r_state;
      if (clear)
         w_state_nxt = PRIME;
      else if (w_accept)
         w_state_nxt = RUN;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= PRIME;
      else
         r_state <= w_state_nxt;
   end

   // Stage 1: window update. The running sum is adjusted by the evicted entry so it
   // stays exact without re-adding the whole buffer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sum  <= '0;
         r_ptr  <= '0;
         r_upd  <= 1'b0;
         r_ferr <= 1'b0;
         for (int i = 0; i < DEPTH; i++)
            r_buf[i] <= '0;
      end else begin
         r_upd  <= w_accept;
         r_ferr <= w_reject;
         if (clear) begin
            r_sum <= '0;
            r_ptr <= '0;
         end else if (w_accept) begin
            if (r_state == PRIME) begin
               for (int i = 0; i < DEPTH; i++)
                  r_buf[i] <= w_sample;
               r_sum <= {w_sample, {AVG_LOG2{1'b0}}};
               r_ptr <= '0;
            end else begin
               r_buf[r_ptr] <= w_sample;
               r_sum        <= r_sum - SUM_W'(r_buf[r_ptr]) + SUM_W'(w_sample);
               r_ptr        <= r_ptr + 1'b1;
            end
         end
      end
   end

   // Stage 2: publish the average and apply hysteresis on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_avg     <= '0;
         r_avg_vld <= 1'b0;
         r_dark    <= 1'b0;
      end else begin
         r_avg_vld <= r_upd & ~clear;
         if (clear) begin
            r_avg  <= '0;
            r_dark <= 1'b0;
         end else begin
            if (r_upd) begin
               r_avg <= w_avg_new;
               if (w_avg_new < TH_LOW)
                  r_dark <= 1'b1;
               else if (w_avg_new > TH_HIGH)
                  r_dark <= 1'b0;
            end
            if (w_stale)
               r_dark <= 1'b0;
         end
      end
   end

`ifdef LIGHT_STALE_EN
   localparam int SCNT_W = $clog2(STALE_CYCLES + 1);

   logic [SCNT_W-1:0] r_scnt;
   logic              r_stale;

   // Any strobe, good or bad, proves the link is alive; only a good sample ends stale.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_scnt  <= '0;
         r_stale <= 1'b0;
      end else if (word_valid) begin
         r_scnt <= '0;
         if (w_accept)
            r_stale <= 1'b0;
      end else if (!r_stale) begin
         if (r_scnt == SCNT_W'(STALE_CYCLES - 1))
            r_stale <= 1'b1;
         else
            r_scnt <= r_scnt + 1'b1;
      end
   end

   assign w_stale = r_stale;
`else
   assign w_stale = 1'b0;
`endif

   assign w_dark_out = r_dark & ~w_stale;
   assign w_duty     = w_dark_out ? (PWM_BITS'(~r_avg) << (PWM_BITS - SAMPLE_W)) : '0;

   pwm_gen #(
      .PWM_BITS (PWM_BITS)
   ) u_pwm_gen (
      .clk    (clk),
      .rst    (reset),
      .i_zero (clear | w_stale),
      .i_duty (w_duty),
      .o_pwm  (pwm_out)
   );

   assign avg_val   = r_avg;
   assign avg_valid = r_avg_vld;
   assign dark      = w_dark_out;
   assign frame_err = r_ferr;
   assign stale     = w_stale;

endmodule
